// File: rtl/bus_pkg.sv
// Shared definitions for the bus endpoint FIFO slice: ID width,
// broadcast address, FIFO occupancy states and sizing helpers.
package bus_pkg;

    localparam int ID_W = 8;
    localparam int PKT_MAX = 64;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Destination ID lives in the top byte of the packet.
    function automatic logic [ID_W-1:0] dest_of(
        input logic [PKT_MAX-1:0] pkt,
        input int                 pkt_sz
    );
        return pkt[pkt_sz-1 -: ID_W];
    endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// First-word-fall-through synchronous FIFO used for both endpoint paths.
// Ports: clk, reset (async, active-low), wr_en/wr_data, rd_en/rd_data,
// count (0..DEPTH), full, empty. A write while full succeeds only when
// a read happens in the same cycle; callers gate wr_en when they need
// stricter behaviour.
module ep_sync_fifo
    import bus_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fifo_state_e      state_q, state_d;
    logic             do_wr, do_rd;

    assign empty = (state_q == FIFO_EMPTY);
    assign full  = (state_q == FIFO_FULL);
    assign count = count_q;

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Storage is not reset; the empty flag masks stale contents.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy state is registered alongside the count it follows.
    always_comb begin
        state_d = FIFO_PARTIAL;
        if (count_d == '0) begin
            state_d = FIFO_EMPTY;
        end else if (count_d == CNT_W'(DEPTH)) begin
            state_d = FIFO_FULL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= FIFO_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/bus_endpoint_fifo.sv
// Device-side bus endpoint: TX FIFO drained by the bus (pndng/pop/D_pop),
// RX FIFO filled by the bus (push/D_push) and drained by the device via
// rx_valid/rx_ready. Ports: clk, reset (async, active-low), tx_valid,
// tx_ready, tx_data, pndng, pop, D_pop, push, D_push, rx_valid, rx_ready,
// rx_data, tx_count, rx_count, rx_ovf_cnt (saturating drop counter).
// Optional macro BUS_ENDPOINT_ADDR_FILTER_EN: drop pushes not addressed
// to ID or BROADCAST without counting them as overflow.
module bus_endpoint_fifo
    import bus_pkg::*;
#(
    parameter int              PCKG_SZ   = 16,
    parameter int              DEPTH     = 8,
    parameter logic [ID_W-1:0] ID        = 8'h00,
    parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    input  logic [PCKG_SZ-1:0]           tx_data,
    output logic                         pndng,
    input  logic                         pop,
    output logic [PCKG_SZ-1:0]           D_pop,
    input  logic                         push,
    input  logic [PCKG_SZ-1:0]           D_push,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [PCKG_SZ-1:0]           rx_data,
    output logic [$clog2(DEPTH+1)-1:0]   tx_count,
    output logic [$clog2(DEPTH+1)-1:0]   rx_count,
    output logic [7:0]                   rx_ovf_cnt
);

    logic       tx_full, tx_empty, tx_wr;
    logic       rx_full, rx_empty;
    logic       addr_match, addr_ok;
    logic       rx_cand, rx_drop;
    logic [7:0] ovf_q, ovf_d;

    // TX: no pass-through when full, even with a same-cycle pop.
    assign tx_ready = !tx_full;
    assign tx_wr    = tx_valid && tx_ready;
    assign pndng    = !tx_empty;

    ep_sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (D_pop),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign addr_match = (dest_of(PKT_MAX'(D_push), PCKG_SZ) == ID) ||
                        (dest_of(PKT_MAX'(D_push), PCKG_SZ) == BROADCAST);

`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
    assign addr_ok = addr_match;
`else
    logic unused_addr_match;
    assign unused_addr_match = addr_match;
    assign addr_ok = 1'b1;
`endif

    // The bus cannot be stalled: a push into a full RX FIFO lands only if
    // the device drains the head in the same cycle, otherwise it is lost.
    assign rx_valid = !rx_empty;
    assign rx_cand  = push && addr_ok;
    assign rx_drop  = rx_cand && rx_full && !rx_ready;

    ep_sync_fifo #(
        .WIDTH (PCKG_SZ),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_cand),
        .wr_data (D_push),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (rx_drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign rx_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Directed bench for bus_endpoint_fifo (PCKG_SZ=16, DEPTH=8, ID=8'h02):
// vector table for basic traffic plus hand sequences for corner cases.
module tb_bus_endpoint_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid, tx_ready;
    logic [15:0] tx_data;
    logic        pndng, pop;
    logic [15:0] D_pop;
    logic        push;
    logic [15:0] D_push;
    logic        rx_valid, rx_ready;
    logic [15:0] rx_data;
    logic [3:0]  tx_count, rx_count;
    logic [7:0]  rx_ovf_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_endpoint_fifo #(
        .PCKG_SZ (16),
        .DEPTH   (8),
        .ID      (8'h02)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .pndng      (pndng),
        .pop        (pop),
        .D_pop      (D_pop),
        .push       (push),
        .D_push     (D_push),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .rx_ovf_cnt (rx_ovf_cnt)
    );

    typedef struct {
        logic        tv;
        logic [15:0] td;
        logic        pp;
        logic        ph;
        logic [15:0] dp;
        logic        rr;
        logic        e_pndng;
        logic [15:0] e_dpop;
        int          e_txc;
        logic        e_txr;
        logic        e_rxv;
        logic [15:0] e_rxd;
        int          e_rxc;
        int          e_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic tv, input logic [15:0] td,
                         input logic pp, input logic ph,
                         input logic [15:0] dp, input logic rr);
        tx_valid = tv;
        tx_data  = td;
        pop      = pp;
        push     = ph;
        D_push   = dp;
        rx_ready = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    logic [15:0] q[$];
    logic [15:0] exp_rx[$];

    initial begin
        vecs[0] = '{1, 16'h0201, 0, 0, 16'h0000, 0,
                    1, 16'h0201, 1, 1, 0, 16'h0000, 0, 0};
        vecs[1] = '{1, 16'h0202, 0, 1, 16'h0233, 0,
                    1, 16'h0201, 2, 1, 1, 16'h0233, 1, 0};
        vecs[2] = '{1, 16'h0203, 1, 1, 16'h0244, 0,
                    1, 16'h0202, 2, 1, 1, 16'h0233, 2, 0};
        vecs[3] = '{0, 16'h0000, 1, 0, 16'h0000, 1,
                    1, 16'h0203, 1, 1, 1, 16'h0244, 1, 0};
        vecs[4] = '{0, 16'h0000, 1, 1, 16'h0255, 1,
                    0, 16'h0000, 0, 1, 1, 16'h0255, 1, 0};
        vecs[5] = '{0, 16'h0000, 1, 0, 16'h0000, 1,
                    0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0};
        vecs[6] = '{0, 16'h0000, 0, 1, 16'hFF11, 0,
                    0, 16'h0000, 0, 1, 1, 16'hFF11, 1, 0};
        vecs[7] = '{0, 16'h0000, 0, 1, 16'h0266, 1,
                    0, 16'h0000, 0, 1, 1, 16'h0266, 1, 0};
        vecs[8] = '{0, 16'h0000, 0, 0, 16'h0000, 1,
                    0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0};

        idle();
        reset = 1'b0;
        repeat (2) tick();
        check("rst_pndng", 32'(pndng), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_dpop", 32'(D_pop), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_tx_count", 32'(tx_count), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_ovf", 32'(rx_ovf_cnt), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].tv, vecs[i].td, vecs[i].pp,
                  vecs[i].ph, vecs[i].dp, vecs[i].rr);
            tick();
            check($sformatf("v%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
            check($sformatf("v%0d_dpop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
            check($sformatf("v%0d_txc", i), 32'(tx_count), 32'(vecs[i].e_txc));
            check($sformatf("v%0d_txr", i), 32'(tx_ready), 32'(vecs[i].e_txr));
            check($sformatf("v%0d_rxv", i), 32'(rx_valid), 32'(vecs[i].e_rxv));
            check($sformatf("v%0d_rxd", i), 32'(rx_data), 32'(vecs[i].e_rxd));
            check($sformatf("v%0d_rxc", i), 32'(rx_count), 32'(vecs[i].e_rxc));
            check($sformatf("v%0d_ovf", i), 32'(rx_ovf_cnt), 32'(vecs[i].e_ovf));
        end
        idle();

        // TX fill to full, then drain
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
            tick();
        end
        check("txfull_count", 32'(tx_count), 32'd8);
        check("txfull_ready", 32'(tx_ready), 32'd0);
        drive(1'b1, 16'h02FF, 1'b1, 1'b0, 16'h0, 1'b0);
        #1;
        check("txfull_ready_with_pop", 32'(tx_ready), 32'd0);
        check("txdrain_head1", 32'(D_pop), 32'h0201);
        tick();
        check("txfull_no_passthru", 32'(tx_count), 32'd7);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            #1;
            check($sformatf("txdrain_head%0d", i), 32'(D_pop), 32'h0200 + 32'(i));
            tick();
        end
        check("txdrain_pndng", 32'(pndng), 32'd0);
        check("txdrain_count", 32'(tx_count), 32'd0);
        idle();

        // RX overflow with device stalled
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
            tick();
        end
        idle();
        #1;
        check("rxovf_count", 32'(rx_count), 32'd8);
        check("rxovf_ovf", 32'(rx_ovf_cnt), 32'd2);
        check("rxovf_head", 32'(rx_data), 32'h0201);

        // RX full, push with simultaneous drain
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h02EE, 1'b1);
        tick();
        check("rxfull_rw_count", 32'(rx_count), 32'd8);
        check("rxfull_rw_ovf", 32'(rx_ovf_cnt), 32'd2);
        check("rxfull_rw_head", 32'(rx_data), 32'h0202);
        exp_rx = '{16'h0202, 16'h0203, 16'h0204, 16'h0205,
                   16'h0206, 16'h0207, 16'h0208, 16'h02EE};
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rxdrain_%0d", k), 32'(rx_data), 32'(exp_rx[k]));
            tick();
        end
        check("rxdrain_valid", 32'(rx_valid), 32'd0);
        idle();

        // Destination filter
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h05AA, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF11, 1'b0);
        tick();
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0222, 1'b0);
        tick();
        idle();
`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
        exp_rx = '{16'hFF11, 16'h0222};
`else
        exp_rx = '{16'h05AA, 16'hFF11, 16'h0222};
`endif
        check("filt_count", 32'(rx_count), 32'(exp_rx.size()));
        check("filt_ovf", 32'(rx_ovf_cnt), 32'd2);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < exp_rx.size(); k++) begin
            #1;
            check($sformatf("filt_order_%0d", k), 32'(rx_data), 32'(exp_rx[k]));
            tick();
        end
        check("filt_empty", 32'(rx_valid), 32'd0);
        idle();

        // TX interleaved write/pop across pointer wrap
        q.delete();
        for (int i = 0; i < 20; i++) begin
            logic do_pop;
            do_pop = (i % 4 != 0) && (q.size() != 0);
            drive(1'b1, 16'h0300 + 16'(i), do_pop, 1'b0, 16'h0, 1'b0);
            #1;
            if (q.size() != 0) begin
                check($sformatf("wrap_head_%0d", i), 32'(D_pop), 32'(q[0]));
            end
            tick();
            if (do_pop) void'(q.pop_front());
            if (q.size() < 8) q.push_back(16'h0300 + 16'(i));
        end
        check("wrap_count", 32'(tx_count), 32'(q.size()));
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        while (q.size() != 0) begin
            #1;
            check("wrap_drain", 32'(D_pop), 32'(q[0]));
            tick();
            void'(q.pop_front());
        end
        check("wrap_empty", 32'(pndng), 32'd0);
        idle();

        // Overflow counter saturation: 8 accepted, 300 dropped
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0277, 1'b0);
        repeat (308) tick();
        idle();
        #1;
        check("sat_ovf", 32'(rx_ovf_cnt), 32'd255);
        check("sat_rx_count", 32'(rx_count), 32'd8);

        // Asynchronous reset in the middle of a TX burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0230 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
            tick();
        end
        check("burst_count", 32'(tx_count), 32'd3);
        drive(1'b1, 16'h0240, 1'b0, 1'b0, 16'h0, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        check("midrst_pndng", 32'(pndng), 32'd0);
        check("midrst_tx_count", 32'(tx_count), 32'd0);
        check("midrst_dpop", 32'(D_pop), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_rx_count", 32'(rx_count), 32'd0);
        check("midrst_ovf", 32'(rx_ovf_cnt), 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'h02AB, 1'b0, 1'b0, 16'h0, 1'b0);
        tick();
        idle();
        check("postrst_head", 32'(D_pop), 32'h02AB);
        check("postrst_count", 32'(tx_count), 32'd1);
        check("postrst_pndng", 32'(pndng), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
